// File: rtl/numimg_reg_reader_pkg.sv
// rtl/numimg_reg_reader_pkg.sv - shared constants, state encoding and byte select helper
package numimg_reg_reader_pkg;

  // FSM state encoding, kept as plain 2-bit constants so older tools
  // and waveform scripts that match on raw values keep working.
  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_SEND  = 2'd3;

  // The image-count register is 32 bits, sent as four bytes.
  localparam int NUMIMG_BYTES           = 4;
  localparam int BYTE_IDX_W             = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  // Byte index 0 is the most significant byte, so the host sees the
  // nav count first and the science count last.
  function automatic logic [7:0] numimg_byte_sel(input logic [31:0]           shadow,
                                                 input logic [BYTE_IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = shadow[31:24];
      2'd1:    b = shadow[23:16];
      2'd2:    b = shadow[15:8];
      default: b = shadow[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/numimg_reg_reader_serializer.sv
// rtl/numimg_reg_reader_serializer.sv - 32-bit shadow emitted as four bytes over valid/ready
module numimg_byte_serializer
  import numimg_reg_reader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        byte_ready_i,
  output logic [7:0]  byte_o,
  output logic        byte_valid_o,
  output logic        last_xfer_o
);

  logic [31:0]           shadow_q, shadow_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [7:0]            byte_q, byte_d;
  logic                  valid_q, valid_d;

  logic xfer;
  logic last_idx;

  assign xfer        = valid_q & byte_ready_i;
  assign last_idx    = (idx_q == BYTE_IDX_W'(NUMIMG_BYTES - 1));
  assign last_xfer_o = xfer & last_idx;

  // Next-state: a load primes the first byte; each transfer steps to the next
  // byte, and the final transfer drops valid. Load wins if both ever coincide.
  always_comb begin
    shadow_d = shadow_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    valid_d  = valid_q;
    if (load_i) begin
      shadow_d = load_data_i;
      idx_d    = '0;
      byte_d   = numimg_byte_sel(load_data_i, '0);
      valid_d  = 1'b1;
    end else if (xfer) begin
      if (last_idx) begin
        idx_d   = '0;
        byte_d  = '0;
        valid_d = 1'b0;
      end else begin
        idx_d  = idx_q + BYTE_IDX_W'(1);
        byte_d = numimg_byte_sel(shadow_q, idx_q + BYTE_IDX_W'(1));
      end
    end
  end

  // State registers; out_byte is held here so it stays stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;

endmodule

// File: rtl/numimg_reg_reader.sv
// rtl/numimg_reg_reader.sv - flushes the image-count register and streams it to the host
module numimg_reg_reader
  import numimg_reg_reader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_rd_req,
  output logic        start_flush_numimg_reg,
  input  logic [31:0] in_numimg_reg,
  input  logic        in_valid_numimg_reg,
  output logic [7:0]  out_byte,
  output logic        out_byte_valid,
  input  logic        in_byte_ready,
  output logic        out_busy,
  output logic        out_done,
  output logic        out_timeout
);

  // Counter must be able to hold TIMEOUT_CYCLES itself; it never wraps
  // because reaching the limit always leaves WAIT.
  localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             flush_q, busy_q, done_q, timeout_q;
  logic             done_d, timeout_d;
  logic             load;
  logic             last_xfer;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Control FSM: request -> one flush cycle -> wait for register -> send.
  // In WAIT, valid is checked before the limit so a late answer still wins.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (in_rd_req) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (in_valid_numimg_reg) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_SEND: begin
        if (last_xfer) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered state and outputs, derived from the next state so each
  // output lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flush_q   <= (state_d == ST_FLUSH) || (state_d == ST_WAIT);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  numimg_byte_serializer u_ser (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .load_data_i  (in_numimg_reg),
    .byte_ready_i (in_byte_ready),
    .byte_o       (out_byte),
    .byte_valid_o (out_byte_valid),
    .last_xfer_o  (last_xfer)
  );

  assign start_flush_numimg_reg = flush_q;
  assign out_busy               = busy_q;
  assign out_done               = done_q;
  assign out_timeout            = timeout_q;

endmodule

// File: tb/tb_numimg_reg_reader.sv
// tb/tb_numimg_reg_reader.sv - scoreboard bench for numimg_reg_reader
module tb_numimg_reg_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_rd_req;
  logic        start_flush_numimg_reg;
  logic [31:0] in_numimg_reg;
  logic        in_valid_numimg_reg;
  logic [7:0]  out_byte;
  logic        out_byte_valid;
  logic        in_byte_ready;
  logic        out_busy;
  logic        out_done;
  logic        out_timeout;

  always #5 clk = ~clk;

  numimg_reg_reader #(.TIMEOUT_CYCLES(16)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_rd_req              (in_rd_req),
    .start_flush_numimg_reg (start_flush_numimg_reg),
    .in_numimg_reg          (in_numimg_reg),
    .in_valid_numimg_reg    (in_valid_numimg_reg),
    .out_byte               (out_byte),
    .out_byte_valid         (out_byte_valid),
    .in_byte_ready          (in_byte_ready),
    .out_busy               (out_busy),
    .out_done               (out_done),
    .out_timeout            (out_timeout)
  );

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];
  int         xfer_cnt = 0;
  int         done_cnt = 0;
  int         tmo_cnt  = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_byte_valid && in_byte_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_byte: got 0x%0h expected no transfer", out_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          check("byte_order", {24'h0, out_byte}, {24'h0, mon_exp});
        end
      end
      if (prev_stall && out_byte_valid)
        check("byte_stable", {24'h0, out_byte}, {24'h0, prev_byte});
      if (out_done)    done_cnt++;
      if (out_timeout) tmo_cnt++;
    end
    prev_stall = out_byte_valid && !in_byte_ready && !rst;
    prev_byte  = out_byte;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(w[31-8*i -: 8]);
  endtask

  // Leaves the DUT in its first SEND cycle.
  task automatic issue_read(input logic [31:0] w, input int wait_cycles);
    in_rd_req = 1'b1;
    tick;
    in_rd_req = 1'b0;
    tick;
    repeat (wait_cycles) tick;
    in_numimg_reg       = w;
    in_valid_numimg_reg = 1'b1;
    tick;
    in_valid_numimg_reg = 1'b0;
    in_numimg_reg       = 32'h0;
  endtask

  task automatic run_send(input bit toggle, input bit inject, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      in_byte_ready = toggle ? (i % 2 == 1) : 1'b1;
      if (inject && (i == 2 || i == 5)) begin
        in_rd_req           = 1'b1;
        in_valid_numimg_reg = 1'b1;
        in_numimg_reg       = 32'hDEAD_BEEF;
      end
      tick;
      in_rd_req           = 1'b0;
      in_valid_numimg_reg = 1'b0;
      in_numimg_reg       = 32'h0;
      if (out_done) seen = 1'b1;
    end
    in_byte_ready = 1'b1;
    check({name, "_done"}, {31'h0, seen}, 32'h1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_flush"},   {31'h0, start_flush_numimg_reg}, 32'h0);
    check({name, "_byte"},    {24'h0, out_byte},               32'h0);
    check({name, "_valid"},   {31'h0, out_byte_valid},         32'h0);
    check({name, "_busy"},    {31'h0, out_busy},               32'h0);
    check({name, "_done"},    {31'h0, out_done},               32'h0);
    check({name, "_timeout"}, {31'h0, out_timeout},            32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, t0, d0;
    rst                 = 1'b1;
    in_rd_req           = 1'b0;
    in_numimg_reg       = 32'h0;
    in_valid_numimg_reg = 1'b0;
    in_byte_ready       = 1'b0;
    repeat (3) tick;
    check_all_zero("reset");
    rst = 1'b0;
    tick;

    // Basic readout with exact latency and done timing.
    x0 = xfer_cnt;
    in_byte_ready = 1'b1;
    push_word(32'h0003_0011, 4);
    in_rd_req = 1'b1;
    tick;
    in_rd_req = 1'b0;
    check("flush_cycle_flush", {31'h0, start_flush_numimg_reg}, 32'h1);
    check("flush_cycle_busy",  {31'h0, out_busy},               32'h1);
    check("flush_cycle_valid", {31'h0, out_byte_valid},         32'h0);
    tick;
    check("wait_flush_held", {31'h0, start_flush_numimg_reg}, 32'h1);
    in_numimg_reg       = 32'h0003_0011;
    in_valid_numimg_reg = 1'b1;
    tick;
    in_valid_numimg_reg = 1'b0;
    in_numimg_reg       = 32'h0;
    check("latency_valid",  {31'h0, out_byte_valid},         32'h1);
    check("first_byte",     {24'h0, out_byte},               32'h00);
    check("send_flush_off", {31'h0, start_flush_numimg_reg}, 32'h0);
    repeat (3) tick;
    check("pre_done",      {31'h0, out_done}, 32'h0);
    check("pre_done_busy", {31'h0, out_busy}, 32'h1);
    tick;
    check("done_pulse",  {31'h0, out_done},       32'h1);
    check("done_busy",   {31'h0, out_busy},       32'h0);
    check("done_valid",  {31'h0, out_byte_valid}, 32'h0);
    tick;
    check("done_one_cycle", {31'h0, out_done}, 32'h0);
    check("basic_xfers", xfer_cnt - x0, 32'd4);

    // Register never answers: timeout after 16 WAIT cycles.
    x0 = xfer_cnt;
    t0 = tmo_cnt;
    in_rd_req = 1'b1;
    tick;
    in_rd_req = 1'b0;
    tick;
    repeat (15) tick;
    check("wait16_no_tmo", {31'h0, out_timeout},            32'h0);
    check("wait16_flush",  {31'h0, start_flush_numimg_reg}, 32'h1);
    tick;
    check("tmo_pulse", {31'h0, out_timeout},            32'h1);
    check("tmo_busy",  {31'h0, out_busy},               32'h0);
    check("tmo_flush", {31'h0, start_flush_numimg_reg}, 32'h0);
    tick;
    check("tmo_one_cycle", {31'h0, out_timeout}, 32'h0);
    check("tmo_count",  tmo_cnt - t0,  32'd1);
    check("tmo_xfers",  xfer_cnt - x0, 32'd0);

    // Valid on the 16th WAIT cycle wins over the timeout.
    t0 = tmo_cnt;
    push_word(32'h1234_5678, 4);
    issue_read(32'h1234_5678, 15);
    check("edge_no_tmo", {31'h0, out_timeout},    32'h0);
    check("edge_valid",  {31'h0, out_byte_valid}, 32'h1);
    check("edge_byte",   {24'h0, out_byte},       32'h12);
    run_send(1'b0, 1'b0, 10, "edge");
    check("edge_tmo_count", tmo_cnt - t0, 32'd0);

    // Ready toggling: in-order bytes, stable across stalls.
    x0 = xfer_cnt;
    in_byte_ready = 1'b0;
    push_word(32'hAABB_CCDD, 4);
    issue_read(32'hAABB_CCDD, 0);
    run_send(1'b1, 1'b0, 20, "toggle");
    check("toggle_xfers", xfer_cnt - x0, 32'd4);

    // Stray valid in IDLE, then rd_req and valid injected mid-SEND.
    in_numimg_reg       = 32'h5555_5555;
    in_valid_numimg_reg = 1'b1;
    tick;
    in_valid_numimg_reg = 1'b0;
    in_numimg_reg       = 32'h0;
    check("stray_idle_busy",  {31'h0, out_busy},       32'h0);
    check("stray_idle_valid", {31'h0, out_byte_valid}, 32'h0);
    x0 = xfer_cnt;
    d0 = done_cnt;
    in_byte_ready = 1'b0;
    push_word(32'h0102_0304, 4);
    issue_read(32'h0102_0304, 0);
    run_send(1'b1, 1'b1, 20, "inject");
    tick;
    check("inject_busy",  {31'h0, out_busy},               32'h0);
    check("inject_flush", {31'h0, start_flush_numimg_reg}, 32'h0);
    check("inject_xfers", xfer_cnt - x0, 32'd4);
    check("inject_dones", done_cnt - d0, 32'd1);

    // Reset after two bytes, with a coincident rd_req that must be dropped.
    d0 = done_cnt;
    in_byte_ready = 1'b1;
    push_word(32'hCAFE_F00D, 2);
    issue_read(32'hCAFE_F00D, 1);
    tick;
    tick;
    in_byte_ready = 1'b0;
    rst           = 1'b1;
    in_rd_req     = 1'b1;
    tick;
    rst       = 1'b0;
    in_rd_req = 1'b0;
    check_all_zero("midsend_rst");
    tick;
    check("rst_req_dropped", {31'h0, out_busy}, 32'h0);
    check("rst_no_done",     done_cnt - d0,     32'd0);
    push_word(32'h0BAD_F00D, 4);
    in_byte_ready = 1'b1;
    issue_read(32'h0BAD_F00D, 0);
    run_send(1'b0, 1'b0, 10, "post_rst");

    repeat (3) tick;
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
